// File: rtl/ref_mem_pkg.sv
// ref_mem_ctrl shared types, sizes and helpers.
// Optional perf counter build macro: REF_MEM_CTRL_PERF_EN.
package ref_mem_pkg;
    localparam int NUM_BANKS = 32;
    localparam int PIXEL     = 8;
    localparam int ADDR_W    = 7;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int DATA_W    = NUM_BANKS * PIXEL;
    localparam int WADDR_W   = NUM_BANKS * ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_SCAN
    } state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(
        input logic [BANK_W-1:0] idx
    );
        logic [NUM_BANKS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/ref_mem_ctrl_if.sv
// ref_mem_ctrl bus: load/scan control, row stream, memory controls.
// REF_MEM_CTRL_PERF_EN adds the stall_cnt status output.
interface ref_mem_ctrl_if;
    import ref_mem_pkg::*;

    logic                 load_start;
    logic [ADDR_W-1:0]    load_rows;
    logic                 ref_in_valid;
    logic                 ref_in_ready;
    logic [DATA_W-1:0]    ref_in_data;
    logic                 scan_start;
    logic [ADDR_W-1:0]    scan_rows;
    logic                 scan_mode;
    logic [3:0]           scan_sel;
    logic [DATA_W-1:0]    ref_input;
    logic [NUM_BANKS-1:0] Bank_sel;
    logic [WADDR_W-1:0]   write_address_all;
    logic [ADDR_W-1:0]    rd_address;
    logic                 rd8R_en;
    logic [3:0]           rdR_sel;
    logic                 busy;
    logic                 loaded;
    logic                 load_done;
    logic                 scan_done;
`ifdef REF_MEM_CTRL_PERF_EN
    logic [15:0]          stall_cnt;

    modport master (
        output load_start, load_rows, ref_in_valid, ref_in_data,
        output scan_start, scan_rows, scan_mode, scan_sel,
        input  ref_in_ready, ref_input, Bank_sel, write_address_all,
        input  rd_address, rd8R_en, rdR_sel,
        input  busy, loaded, load_done, scan_done, stall_cnt
    );

    modport slave (
        input  load_start, load_rows, ref_in_valid, ref_in_data,
        input  scan_start, scan_rows, scan_mode, scan_sel,
        output ref_in_ready, ref_input, Bank_sel, write_address_all,
        output rd_address, rd8R_en, rdR_sel,
        output busy, loaded, load_done, scan_done, stall_cnt
    );
`else
    modport master (
        output load_start, load_rows, ref_in_valid, ref_in_data,
        output scan_start, scan_rows, scan_mode, scan_sel,
        input  ref_in_ready, ref_input, Bank_sel, write_address_all,
        input  rd_address, rd8R_en, rdR_sel,
        input  busy, loaded, load_done, scan_done
    );

    modport slave (
        input  load_start, load_rows, ref_in_valid, ref_in_data,
        input  scan_start, scan_rows, scan_mode, scan_sel,
        output ref_in_ready, ref_input, Bank_sel, write_address_all,
        output rd_address, rd8R_en, rdR_sel,
        output busy, loaded, load_done, scan_done
    );
`endif
endinterface

// File: rtl/ref_mem_wr_seq.sv
// Write sequencer: bank/row counters and registered memory write port.
// o_last flags the beat that completes the window.
module ref_mem_wr_seq
    import ref_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_fire,
    input  logic [ADDR_W-1:0]    i_rows,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_last,
    output logic                 o_wr_last,
    output logic [NUM_BANKS-1:0] o_bank_sel,
    output logic [DATA_W-1:0]    o_ref_input,
    output logic [WADDR_W-1:0]   o_wr_addr_all
);
    logic [BANK_W-1:0]    r_bank_ptr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic                 r_wr_last;
    logic [NUM_BANKS-1:0] r_bank_sel;
    logic [DATA_W-1:0]    r_ref_input;
    logic [WADDR_W-1:0]   r_wr_addr_all;
    logic                 w_bank_wrap;

    assign w_bank_wrap = (r_bank_ptr == BANK_W'(NUM_BANKS - 1));
    assign o_last      = w_bank_wrap && (r_wr_addr == i_rows - ADDR_W'(1));

    // Walk banks lane by lane; row address advances on each bank wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_ptr <= '0;
            r_wr_addr  <= '0;
        end else if (i_clr) begin
            r_bank_ptr <= '0;
            r_wr_addr  <= '0;
        end else if (i_fire) begin
            r_bank_ptr <= w_bank_wrap ? '0 : r_bank_ptr + BANK_W'(1);
            if (w_bank_wrap) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
        end
    end

    // Register the write port; everything idles to zero without a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel    <= '0;
            r_ref_input   <= '0;
            r_wr_addr_all <= '0;
            r_wr_last     <= 1'b0;
        end else if (i_fire) begin
            r_bank_sel    <= bank_onehot(r_bank_ptr);
            r_ref_input   <= i_data;
            r_wr_addr_all <= {NUM_BANKS{r_wr_addr}};
            r_wr_last     <= o_last;
        end else begin
            r_bank_sel    <= '0;
            r_ref_input   <= '0;
            r_wr_addr_all <= '0;
            r_wr_last     <= 1'b0;
        end
    end

    assign o_wr_last     = r_wr_last;
    assign o_bank_sel    = r_bank_sel;
    assign o_ref_input   = r_ref_input;
    assign o_wr_addr_all = r_wr_addr_all;
endmodule

// File: rtl/ref_mem_ctrl.sv
// Reference memory sequencer: window load FSM, read scan and status.
// Define REF_MEM_CTRL_PERF_EN to add the stall_cnt perf counter.
module ref_mem_ctrl
    import ref_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ref_mem_ctrl_if.slave bus
);
    state_t               r_state;
    logic [ADDR_W-1:0]    r_load_rows;
    logic [ADDR_W-1:0]    r_scan_rows;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W-1:0]    r_rd_address;
    logic                 r_scan_mode;
    logic [3:0]           r_scan_sel;
    logic                 r_rd8R_en;
    logic [3:0]           r_rdR_sel;
    logic                 r_loaded;
    logic                 r_load_done;
    logic                 r_scan_done;

    logic                 w_ready;
    logic                 w_fire;
    logic                 w_can_load;
    logic                 w_ld_go;
    logic                 w_sc_go;
    logic                 w_last;
    logic                 w_wr_last;
    logic [NUM_BANKS-1:0] w_bank_sel;
    logic [DATA_W-1:0]    w_ref_input;
    logic [WADDR_W-1:0]   w_wr_addr_all;

    assign w_ready    = (r_state == S_LOAD);
    assign w_fire     = w_ready && bus.ref_in_valid;
    assign w_can_load = (r_state == S_IDLE) || (r_state == S_LOADED);
    assign w_ld_go    = bus.load_start && (bus.load_rows != '0) && w_can_load;
    assign w_sc_go    = bus.scan_start && (bus.scan_rows != '0)
                     && (r_state == S_LOADED) && !w_ld_go;

    ref_mem_wr_seq u_wr_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_ld_go),
        .i_fire        (w_fire),
        .i_rows        (r_load_rows),
        .i_data        (bus.ref_in_data),
        .o_last        (w_last),
        .o_wr_last     (w_wr_last),
        .o_bank_sel    (w_bank_sel),
        .o_ref_input   (w_ref_input),
        .o_wr_addr_all (w_wr_addr_all)
    );

    // Main FSM with registered read port and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_load_rows  <= '0;
            r_scan_rows  <= '0;
            r_rd_ptr     <= '0;
            r_rd_address <= '0;
            r_scan_mode  <= 1'b0;
            r_scan_sel   <= '0;
            r_rd8R_en    <= 1'b0;
            r_rdR_sel    <= '0;
            r_loaded     <= 1'b0;
            r_load_done  <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_scan_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_ld_go) begin
                        r_state     <= S_LOAD;
                        r_load_rows <= bus.load_rows;
                        r_loaded    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_fire && w_last) begin
                        r_state <= S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (w_ld_go) begin
                        r_state     <= S_LOAD;
                        r_load_rows <= bus.load_rows;
                        r_loaded    <= 1'b0;
                    end else if (w_sc_go) begin
                        r_state      <= S_SCAN;
                        r_scan_rows  <= bus.scan_rows;
                        r_scan_mode  <= bus.scan_mode;
                        r_scan_sel   <= bus.scan_sel;
                        r_rd_address <= '0;
                        r_rd8R_en    <= bus.scan_mode;
                        r_rdR_sel    <= bus.scan_sel;
                        r_rd_ptr     <= ADDR_W'(1);
                    end
                end
                S_SCAN: begin
                    if (r_rd_ptr == r_scan_rows) begin
                        r_state      <= S_LOADED;
                        r_rd_address <= '0;
                        r_rd8R_en    <= 1'b0;
                        r_rdR_sel    <= '0;
                        r_rd_ptr     <= '0;
                        r_scan_done  <= 1'b1;
                    end else begin
                        r_rd_address <= r_rd_ptr;
                        r_rd8R_en    <= r_scan_mode;
                        r_rdR_sel    <= r_scan_sel;
                        r_rd_ptr     <= r_rd_ptr + ADDR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A reload in the same cycle cancels the pending completion.
            if (w_wr_last && !w_ld_go) begin
                r_load_done <= 1'b1;
                r_loaded    <= 1'b1;
            end
        end
    end

`ifdef REF_MEM_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;

    // Count starved LOAD cycles, saturating; restart on every load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_ld_go) begin
            r_stall_cnt <= '0;
        end else if (w_ready && !bus.ref_in_valid
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.ref_in_ready      = w_ready;
    assign bus.Bank_sel          = w_bank_sel;
    assign bus.ref_input         = w_ref_input;
    assign bus.write_address_all = w_wr_addr_all;
    assign bus.rd_address        = r_rd_address;
    assign bus.rd8R_en           = r_rd8R_en;
    assign bus.rdR_sel           = r_rdR_sel;
    assign bus.busy              = (r_state == S_LOAD) || (r_state == S_SCAN);
    assign bus.loaded            = r_loaded;
    assign bus.load_done         = r_load_done;
    assign bus.scan_done         = r_scan_done;
endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Self-checking bench for ref_mem_ctrl: scenario table, hand sequences
// and a randomized run against a cycle-timeline reference model.
module tb_ref_mem_ctrl;
    import ref_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ref_mem_ctrl_if bus();

    ref_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_LOADED = 2;
    localparam int P_SCAN   = 3;

    // model state
    int         m_ph;
    int         m_k;
    int         m_total;
    int         m_ld_done_cyc;
    int         m_S;
    int         m_srows;
    bit         m_mode;
    logic [3:0] m_sel;
    bit         m_loaded;
    int         m_stall;

    // expected outputs for the next observed cycle
    logic [31:0]  e_sel;
    logic [255:0] e_data;
    logic [223:0] e_waddr;
    int           e_rd;
    bit           e_rd8;
    int           e_rdsel;
    bit           e_ld_done;
    bit           e_sc_done;

    // independent event counters taken from DUT outputs
    int n_writes;
    int n_scan;
    int n_ld;
    int n_sd;

    typedef struct {
        int         lrows;
        int         vpat;
        int         srows;
        bit         smode;
        logic [3:0] ssel;
        int         exp_writes;
        int         exp_scan;
    } vec_t;

    vec_t vt[4];

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                         name, cyc, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%h exp=%h",
                         name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_ph          = P_IDLE;
        m_k           = 0;
        m_total       = 0;
        m_ld_done_cyc = -100;
        m_S           = -100;
        m_srows       = 0;
        m_mode        = 1'b0;
        m_sel         = '0;
        m_loaded      = 1'b0;
        m_stall       = 0;
    endtask

    task automatic clr_in();
        bus.load_start   = 1'b0;
        bus.load_rows    = '0;
        bus.scan_start   = 1'b0;
        bus.scan_rows    = '0;
        bus.scan_mode    = 1'b0;
        bus.scan_sel     = '0;
        bus.ref_in_valid = 1'b0;
        bus.ref_in_data  = '0;
    endtask

    // Predict the cycle after the current one from the inputs now applied.
    task automatic model_step();
        bit ld_go;
        bit sc_go;
        bit hs;
        ld_go = bus.load_start && (bus.load_rows != 0)
             && (m_ph == P_IDLE || m_ph == P_LOADED);
        sc_go = bus.scan_start && (bus.scan_rows != 0)
             && (m_ph == P_LOADED) && !ld_go;
        hs    = bus.ref_in_valid && (m_ph == P_LOAD);
        if (ld_go) m_stall = 0;
        else if (m_ph == P_LOAD && !bus.ref_in_valid && m_stall < 65535)
            m_stall++;
        e_sel     = '0;
        e_data    = '0;
        e_waddr   = '0;
        e_rd      = 0;
        e_rd8     = 1'b0;
        e_rdsel   = 0;
        e_sc_done = 1'b0;
        e_ld_done = (cyc + 1 == m_ld_done_cyc) && !ld_go;
        if (ld_go) m_loaded = 1'b0;
        if (e_ld_done) m_loaded = 1'b1;
        if (hs) begin
            e_sel  = 32'h1 << (m_k % 32);
            e_data = bus.ref_in_data;
            for (int b = 0; b < 32; b++) e_waddr[b*7 +: 7] = 7'(m_k / 32);
        end
        if (ld_go) begin
            m_ph          = P_LOAD;
            m_k           = 0;
            m_total       = int'(bus.load_rows) * 32;
            m_ld_done_cyc = -100;
        end else if (sc_go) begin
            m_ph    = P_SCAN;
            m_S     = cyc;
            m_srows = int'(bus.scan_rows);
            m_mode  = bus.scan_mode;
            m_sel   = bus.scan_sel;
        end else if (hs) begin
            m_k++;
            if (m_k == m_total) begin
                m_ph          = P_LOADED;
                m_ld_done_cyc = cyc + 2;
            end
        end
        if (m_ph == P_SCAN) begin
            if (cyc + 1 <= m_S + m_srows) begin
                e_rd    = cyc - m_S;
                e_rd8   = m_mode;
                e_rdsel = int'(m_sel);
            end else begin
                e_sc_done = 1'b1;
                m_ph      = P_LOADED;
            end
        end
    endtask

    task automatic compare();
        chk_i("ready", int'(bus.ref_in_ready), int'(m_ph == P_LOAD));
        chk_i("bank_sel", int'(bus.Bank_sel), int'(e_sel));
        chk_w("ref_input", 256'(bus.ref_input), e_data);
        chk_w("wr_addr_all", 256'(bus.write_address_all), 256'(e_waddr));
        chk_i("rd_address", int'(bus.rd_address), e_rd);
        chk_i("rd8R_en", int'(bus.rd8R_en), int'(e_rd8));
        chk_i("rdR_sel", int'(bus.rdR_sel), e_rdsel);
        chk_i("busy", int'(bus.busy),
              int'(m_ph == P_LOAD || m_ph == P_SCAN));
        chk_i("loaded", int'(bus.loaded), int'(m_loaded));
        chk_i("load_done", int'(bus.load_done), int'(e_ld_done));
        chk_i("scan_done", int'(bus.scan_done), int'(e_sc_done));
`ifdef REF_MEM_CTRL_PERF_EN
        chk_i("stall_cnt", int'(bus.stall_cnt), m_stall);
`endif
        if (bus.Bank_sel != '0) n_writes++;
        if (bus.busy && !bus.ref_in_ready) n_scan++;
        if (bus.load_done) n_ld++;
        if (bus.scan_done) n_sd++;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic zero_counts();
        n_writes = 0;
        n_scan   = 0;
        n_ld     = 0;
        n_sd     = 0;
    endtask

    task automatic do_load(input int rows, input int vpat);
        bus.load_start = 1'b1;
        bus.load_rows  = 7'(rows);
        tick();
        clr_in();
        for (int i = 0; i < 2000 && !bus.loaded; i++) begin
            case (vpat)
                0:       bus.ref_in_valid = 1'b1;
                1:       bus.ref_in_valid = (i % 2 == 0);
                default: bus.ref_in_valid = 1'($urandom % 2);
            endcase
            bus.ref_in_data = rnd_data();
            tick();
        end
        clr_in();
        chk_i("load_completes", int'(bus.loaded), 1);
    endtask

    task automatic do_scan(input int rows, input bit mode,
                           input logic [3:0] sel);
        bus.scan_start = 1'b1;
        bus.scan_rows  = 7'(rows);
        bus.scan_mode  = mode;
        bus.scan_sel   = sel;
        tick();
        clr_in();
        for (int i = 0; i < 300 && !bus.scan_done; i++) tick();
        chk_i("scan_completes", int'(bus.scan_done), 1);
    endtask

    task automatic run_vec(input vec_t v);
        zero_counts();
        do_load(v.lrows, v.vpat);
        chk_i("vec_writes", n_writes, v.exp_writes);
        chk_i("vec_load_done_cnt", n_ld, 1);
        chk_i("vec_ready_dropped", int'(bus.ref_in_ready), 0);
        do_scan(v.srows, v.smode, v.ssel);
        chk_i("vec_scan_cycles", n_scan, v.exp_scan);
        tick();
        chk_i("vec_rd_idle", int'(bus.rd_address) + int'(bus.rd8R_en)
              + int'(bus.rdR_sel), 0);
        do_scan(v.srows, v.smode, v.ssel);
        chk_i("vec_repeat_scan", n_scan, 2 * v.exp_scan);
        chk_i("vec_scan_done_cnt", n_sd, 2);
        tick();
    endtask

    initial begin
        vt[0] = '{lrows: 3, vpat: 0, srows: 4, smode: 1'b1, ssel: 4'd0,
                  exp_writes: 96, exp_scan: 4};
        vt[1] = '{lrows: 2, vpat: 1, srows: 1, smode: 1'b0, ssel: 4'd5,
                  exp_writes: 64, exp_scan: 1};
        vt[2] = '{lrows: 1, vpat: 2, srows: 7, smode: 1'b0, ssel: 4'd9,
                  exp_writes: 32, exp_scan: 7};
        vt[3] = '{lrows: 4, vpat: 2, srows: 127, smode: 1'b1, ssel: 4'd15,
                  exp_writes: 128, exp_scan: 127};

        clr_in();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_i("rst_ready", int'(bus.ref_in_ready), 0);
        chk_i("rst_bank_sel", int'(bus.Bank_sel), 0);
        chk_w("rst_ref_input", 256'(bus.ref_input), '0);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_i("rst_loaded", int'(bus.loaded), 0);
        chk_i("rst_rd_address", int'(bus.rd_address), 0);
        rst_n = 1'b1;
        model_reset();
        zero_counts();

        // starts that must be ignored in IDLE
        bus.scan_start = 1'b1;
        bus.scan_rows  = 7'd3;
        tick();
        clr_in();
        chk_i("idle_scan_ignored", int'(bus.busy), 0);
        bus.load_start = 1'b1;
        bus.load_rows  = 7'd0;
        tick();
        clr_in();
        chk_i("zero_rows_ignored", int'(bus.busy), 0);

        foreach (vt[i]) run_vec(vt[i]);

        // both starts in LOADED: load wins; stray starts during LOAD ignored
        zero_counts();
        bus.load_start = 1'b1;
        bus.load_rows  = 7'd1;
        bus.scan_start = 1'b1;
        bus.scan_rows  = 7'd2;
        tick();
        clr_in();
        chk_i("both_start_load_wins", int'(bus.ref_in_ready), 1);
        for (int i = 0; i < 200 && !bus.loaded; i++) begin
            bus.ref_in_valid = 1'b1;
            bus.ref_in_data  = rnd_data();
            bus.scan_start   = (i == 3);
            bus.scan_rows    = 7'd2;
            bus.load_start   = (i == 5);
            bus.load_rows    = 7'd3;
            tick();
        end
        clr_in();
        chk_i("stray_start_writes", n_writes, 32);
        chk_i("stray_start_scan", n_scan, 0);

`ifdef REF_MEM_CTRL_PERF_EN
        bus.load_start = 1'b1;
        bus.load_rows  = 7'd1;
        tick();
        clr_in();
        for (int i = 0; i < 200 && !bus.loaded; i++) begin
            bus.ref_in_valid = !(i >= 3 && i < 8);
            bus.ref_in_data  = rnd_data();
            tick();
        end
        clr_in();
        chk_i("stall_cnt_5", int'(bus.stall_cnt), 5);
`endif

        // asynchronous reset at beat 10 of a load
        bus.load_start = 1'b1;
        bus.load_rows  = 7'd2;
        tick();
        clr_in();
        for (int i = 0; i < 10; i++) begin
            bus.ref_in_valid = 1'b1;
            bus.ref_in_data  = rnd_data();
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_i("arst_bank_sel", int'(bus.Bank_sel), 0);
        chk_w("arst_ref_input", 256'(bus.ref_input), '0);
        chk_w("arst_wr_addr", 256'(bus.write_address_all), '0);
        chk_i("arst_busy", int'(bus.busy), 0);
        chk_i("arst_ready", int'(bus.ref_in_ready), 0);
        chk_i("arst_loaded", int'(bus.loaded), 0);
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.scan_start = 1'b1;
        bus.scan_rows  = 7'd2;
        tick();
        clr_in();
        chk_i("post_rst_scan_ignored", int'(bus.busy), 0);

        // randomized traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            bus.load_start   = ($urandom % 40 == 0);
            bus.load_rows    = 7'($urandom % 4);
            bus.scan_start   = ($urandom % 6 == 0);
            bus.scan_rows    = 7'($urandom % 9);
            bus.scan_mode    = 1'($urandom % 2);
            bus.scan_sel     = 4'($urandom % 16);
            bus.ref_in_valid = ($urandom % 10 < 7);
            bus.ref_in_data  = rnd_data();
            tick();
        end
        clr_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
